// File: rtl/logicnets_pkg.sv
// logicnets_pkg: shared types, defaults and width helper for the LogicNets front end
package logicnets_pkg;
  typedef enum logic {FILL, WAIT} state_t;
  localparam int DEF_FEAT_BITS = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/logicnets_hold_reg.sv
// logicnets_hold_reg: one-entry valid/ready output register with load, hold and drain
module logicnets_hold_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         space,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] data
);
  // The slot is reusable when empty or when it drains on this edge.
  assign space = !valid || ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (space) begin
      valid <= load;
      if (load) data <= din;
    end
endmodule

// File: rtl/logicnets_input_packer.sv
// logicnets_input_packer: packs NUM_FEATS quantized features into one frame for layer 1
module logicnets_input_packer
  import logicnets_pkg::*;
#(
  parameter int NUM_FEATS = 16,
  parameter int FEAT_BITS = DEF_FEAT_BITS,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [FEAT_BITS-1:0]           s_data,
  input  logic                           s_last,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [NUM_FEATS*FEAT_BITS-1:0] m_data,
  output logic                           err_len,
  output logic [CNT_W-1:0]               frame_cnt
);
  localparam int OUT_W = NUM_FEATS * FEAT_BITS;
  localparam int IW = idx_w(NUM_FEATS);
  localparam logic [IW-1:0] LAST = IW'(NUM_FEATS - 1);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [OUT_W-1:0] frame_q, frame_n, din;
  logic rdy, take, at_end, load, space, err_n;
  assign s_ready = rdy;
  assign take = s_valid && rdy;
  assign at_end = idx == LAST;
  // Assembly view including the feature being written this cycle.
  always_comb begin
    frame_n = frame_q;
    frame_n[idx*FEAT_BITS +: FEAT_BITS] = s_data;
  end
  always_comb begin
    load = (state == WAIT) ? space : take && at_end && space;
    state_n = ((state == WAIT) || (take && at_end)) && !space ? WAIT : FILL;
    idx_n = !take ? idx : (at_end || s_last) ? '0 : idx + 1'b1;
    din = (state == WAIT) ? frame_q : frame_n;
    err_n = take && (at_end ? !s_last : s_last);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      frame_q   <= '0;
      rdy       <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      rdy     <= state_n == FILL;
      err_len <= err_n;
      if (take) frame_q <= frame_n;
      if (m_valid && m_ready) frame_cnt <= frame_cnt + 1'b1;
    end
  logicnets_hold_reg #(.W(OUT_W)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .space (space),
    .valid (m_valid),
    .ready (m_ready),
    .data  (m_data)
  );
endmodule

// File: tb/tb_logicnets_input_packer.sv
// tb_logicnets_input_packer: scoreboard bench with a frame-level reference model
module tb_logicnets_input_packer;
  localparam int N = 4;
  localparam int FB = 2;
  localparam int CW = 4;
  localparam int OW = N * FB;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [FB-1:0] s_data = '0;
  logic s_ready, m_valid, err_len;
  logic [OW-1:0] m_data;
  logic [CW-1:0] frame_cnt;
  logicnets_input_packer #(.NUM_FEATS(N), .FEAT_BITS(FB), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .err_len   (err_len),
    .frame_cnt (frame_cnt)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, passed = 0, stalls = 0;
  logic [OW-1:0] exp_q[$];
  int err_q[$];
  int out_cyc[$];
  int feats[$];
  bit rand_mr = 1'b0;
  logic [CW-1:0] exp_cnt = '0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
    if (rand_mr) m_ready = ($urandom_range(0, 3) != 0);
  endtask
  // Reference: collect features; a full frame is emitted, a short frame ending in last is dropped.
  task automatic accept(input int d, input bit last);
    logic [OW-1:0] f;
    feats.push_back(d);
    if (feats.size() == N) begin
      f = '0;
      foreach (feats[i]) f |= OW'(feats[i]) << (i * FB);
      exp_q.push_back(f);
      if (!last) err_q.push_back(cyc + 1);
      feats.delete();
    end else if (last) begin
      err_q.push_back(cyc + 1);
      feats.delete();
    end
  endtask
  task automatic send(input int d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data = FB'(d);
    s_last = last;
    while (!s_ready && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) check("send_timeout", s_ready, 1);
    else accept(d, last);
    stalls += n;
    tick();
  endtask
  task automatic idle(input int k);
    s_valid = 1'b0;
    s_last = 1'b0;
    repeat (k) tick();
  endtask
  task automatic frame(input int a, input int b, input int c, input int d, input bit last);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, last);
  endtask
  initial begin : monitor
    logic [OW-1:0] prev_data;
    bit prev_stall, chk_next;
    prev_stall = 1'b0;
    chk_next = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_stall = 1'b0;
        chk_next = 1'b0;
        exp_cnt = '0;
        continue;
      end
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
      end
      if (chk_next) check("frame_cnt_inc", frame_cnt, exp_cnt);
      chk_next = 1'b0;
      if (err_len) begin
        if (err_q.size() == 0) check("err_len_unexpected", err_len, 0);
        else check("err_len_cycle", cyc, err_q.pop_front());
      end else if (err_q.size() > 0 && err_q[0] < cyc) begin
        check("err_len_missing", err_len, 1);
        void'(err_q.pop_front());
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("m_valid_unexpected", m_valid, 0);
        else begin
          check("m_data", m_data, exp_q.pop_front());
          check("frame_cnt", frame_cnt, exp_cnt);
        end
        exp_cnt++;
        chk_next = 1'b1;
        out_cyc.push_back(cyc);
      end
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_err_len", err_len, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_s_ready", s_ready, 1);
    m_ready = 1'b1;
    frame(1, 2, 3, 0, 1'b1);
    check("basic_m_valid", m_valid, 1);
    check("basic_m_data", m_data, 8'h39);
    idle(1);
    check("basic_m_valid_drop", m_valid, 0);
    check("basic_frame_cnt", frame_cnt, 1);
    stalls = 0;
    out_cyc.delete();
    frame(1, 2, 3, 0, 1'b1);
    frame(3, 3, 3, 3, 1'b1);
    idle(2);
    check("b2b_stalls", stalls, 0);
    check("b2b_outputs", out_cyc.size(), 2);
    if (out_cyc.size() == 2) check("b2b_spacing", out_cyc[1] - out_cyc[0], 4);
    m_ready = 1'b0;
    frame(1, 2, 3, 0, 1'b1);
    frame(3, 3, 3, 3, 1'b1);
    s_valid = 1'b0;
    check("bp_s_ready_low", s_ready, 0);
    check("bp_m_data", m_data, 8'h39);
    idle(2);
    check("bp_s_ready_held", s_ready, 0);
    check("bp_m_data_held", m_data, 8'h39);
    m_ready = 1'b1;
    tick();
    check("bp_second_valid", m_valid, 1);
    check("bp_second_data", m_data, 8'hFF);
    check("bp_s_ready_back", s_ready, 1);
    idle(2);
    send(1, 1'b0);
    send(2, 1'b1);
    check("early_err_len", err_len, 1);
    check("early_no_output", m_valid, 0);
    idle(1);
    check("early_err_one_cycle", err_len, 0);
    frame(1, 2, 3, 0, 1'b1);
    check("early_next_data", m_data, 8'h39);
    idle(2);
    frame(3, 1, 0, 2, 1'b0);
    check("missing_err_len", err_len, 1);
    check("missing_m_valid", m_valid, 1);
    idle(2);
    n = 0;
    while (exp_cnt != '1 && n < 40) begin
      frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
      idle(2);
      n++;
    end
    check("wrap_all_ones", frame_cnt, 4'hF);
    frame(0, 1, 2, 3, 1'b1);
    idle(2);
    check("wrap_zero", frame_cnt, 0);
    rand_mr = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        n = $urandom_range(0, 15);
        send($urandom_range(0, 3), (feats.size() == N - 1) ? (n != 0) : (n == 0));
      end
    end
    rand_mr = 1'b0;
    m_ready = 1'b1;
    idle(10);
    check("rand_frames_drained", exp_q.size(), 0);
    feats.delete();
    send(1, 1'b0);
    send(2, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    feats.delete();
    exp_q.delete();
    err_q.delete();
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    frame(2, 0, 1, 3, 1'b1);
    check("midrst_m_data", m_data, 8'hD2);
    idle(2);
    check("midrst_frame_cnt", frame_cnt, 1);
    idle(3);
    check("frames_outstanding", exp_q.size(), 0);
    check("errs_outstanding", err_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
